// File: rtl/serial_pattern_tx.sv
// Serial stimulus source for a non-overlapping Mealy "101" detector, with a built-in reference tracker.
// Optional SERIAL_PATTERN_TX_REPEAT_EN adds repeat_en to retransmit the captured word.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
  input  logic             repeat_en,
`endif
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             signal,
  output logic             busy,
  output logic             frame_done,
  output logic             exp_out,
  output logic [7:0]       match_cnt
);
  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);
  localparam logic [7:0]      GAP_LD   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic            GAP_ZERO = (GAP == 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  typedef enum logic [1:0] {T0, T1, T10} trk_t;

  state_t           state, state_nxt;
  trk_t             trk, trk_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt, word, word_nxt, start_word;
  logic [CW-1:0]    bcnt, bcnt_nxt;
  logic [7:0]       gcnt, gcnt_nxt;
  logic             sig_nxt, start, take, rep, last_bit;

`ifdef SERIAL_PATTERN_TX_REPEAT_EN
  assign rep = repeat_en;
`else
  assign rep = 1'b0;
`endif

  assign last_bit   = (state == S_SHIFT) && (bcnt == '0);
  // With no gap the next word can be taken while the last bit is on the line
  assign load_ready = (state == S_IDLE) || (GAP_ZERO && last_bit && !rep);
  assign take       = load_valid && load_ready;
  assign busy       = (state != S_IDLE);
  assign frame_done = last_bit;
  assign exp_out    = (trk == T10) && signal;

  always_comb begin
    state_nxt  = state;
    sreg_nxt   = sreg;
    word_nxt   = word;
    bcnt_nxt   = bcnt;
    gcnt_nxt   = gcnt;
    sig_nxt    = 1'b0;
    start      = 1'b0;
    start_word = load_data;
    case (state)
      S_IDLE: start = take;
      S_SHIFT: begin
        if (bcnt != '0) begin
          sig_nxt  = sreg[WIDTH-1];
          sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
          bcnt_nxt = bcnt - CW'(1);
        end else if (take) begin
          start = 1'b1;
        end else if (GAP_ZERO && rep) begin
          start      = 1'b1;
          start_word = word;
        end else if (!GAP_ZERO) begin
          state_nxt = S_GAP;
          gcnt_nxt  = GAP_LD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (gcnt != 8'd0) begin
          gcnt_nxt = gcnt - 8'd1;
        end else if (rep) begin
          start      = 1'b1;
          start_word = word;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (start) begin
      state_nxt = S_SHIFT;
      sig_nxt   = start_word[WIDTH-1];
      sreg_nxt  = {start_word[WIDTH-2:0], 1'b0};
      bcnt_nxt  = LAST_IDX;
      word_nxt  = start_word;
    end
  end

  // Tracker sees every line value, idle and gap zeros included
  always_comb begin
    trk_nxt = T0;
    case (trk)
      T0:      trk_nxt = signal ? T1 : T0;
      T1:      trk_nxt = signal ? T1 : T10;
      T10:     trk_nxt = T0;
      default: trk_nxt = T0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      trk       <= T0;
      sreg      <= '0;
      word      <= '0;
      bcnt      <= '0;
      gcnt      <= 8'd0;
      signal    <= 1'b0;
      match_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      trk       <= trk_nxt;
      sreg      <= sreg_nxt;
      word      <= word_nxt;
      bcnt      <= bcnt_nxt;
      gcnt      <= gcnt_nxt;
      signal    <= sig_nxt;
      match_cnt <= match_cnt + {7'd0, exp_out};
    end
  end
endmodule
